// File: rtl/light_pkg.sv
// Shared types and constants for the light-code safety monitor.
// Light encoding, head indices, the conflicting-pair table, the illegal
// cause code and the monitor state encoding.
package light_pkg;

   typedef enum logic [1:0] {
      RED    = 2'b00,
      YELLOW = 2'b01,
      GREEN  = 2'b10,
      DARK   = 2'b11
   } light_e;

   typedef enum logic [3:0] {
      H_TH    = 4'd0,
      H_NN    = 4'd1,
      H_NS    = 4'd2,
      H_GTH   = 4'd3,
      H_GNN_L = 4'd4,
      H_GNN_R = 4'd5,
      H_PN    = 4'd6,
      H_PTH1  = 4'd7,
      H_PTH2  = 4'd8
   } head_e;

   localparam int NUM_HEADS   = 9;
   localparam int NUM_PAIRS   = 14;
   localparam int NUM_VEHICLE = 6;   // heads 0..5 are vehicle heads

   // Pair p conflicts when heads PAIR_A[p] and PAIR_B[p] are both non-red.
   localparam head_e PAIR_A [NUM_PAIRS] = '{
      H_TH, H_TH, H_TH, H_TH,
      H_GTH, H_GTH, H_GTH,
      H_PN, H_PN, H_PN,
      H_PTH1, H_PTH2, H_PTH1, H_PTH2
   };
   localparam head_e PAIR_B [NUM_PAIRS] = '{
      H_NN, H_NS, H_GNN_L, H_GNN_R,
      H_NN, H_NS, H_GNN_R,
      H_NN, H_NS, H_GTH,
      H_TH, H_TH, H_GNN_L, H_GNN_R
   };

   // Two-lamp heads have no yellow lamp, so code 01 on them is illegal.
   localparam logic [NUM_HEADS-1:0] TWO_LAMP_MASK = 9'b1_1111_1000;

   localparam logic [3:0] CAUSE_ILLEGAL = 4'd15;

   typedef enum logic [1:0] {
      S_NORMAL = 2'd0,
      S_FAULT  = 2'd1,
      S_ALLRED = 2'd2
   } state_e;

endpackage

// File: rtl/conflict_detect.sv
// Combinational conflict / illegal-code detector.
// Ports:
//   codes     in  9 x 2-bit light codes, indexed by head_e
//   any_cause out at least one conflict pair or illegal code present
//   cause     out prioritized cause: lowest pair index, 15 (illegal) last
module conflict_detect
   import light_pkg::*;
(
   input  logic [NUM_HEADS-1:0][1:0] codes,
   output logic                      any_cause,
   output logic [3:0]                cause
);

   logic illegal;

   always_comb begin
      illegal = 1'b0;
      for (int h = 0; h < NUM_HEADS; h++) begin
         if (TWO_LAMP_MASK[h] && (codes[h] == YELLOW)) illegal = 1'b1;
      end
   end

   // Scan from the highest pair down so the lowest active index wins.
   always_comb begin
      any_cause = illegal;
      cause     = illegal ? CAUSE_ILLEGAL : 4'd0;
      for (int p = NUM_PAIRS - 1; p >= 0; p--) begin
         if ((codes[PAIR_A[p]] != RED) && (codes[PAIR_B[p]] != RED)) begin
            any_cause = 1'b1;
            cause     = 4'(p);
         end
      end
   end

endmodule

// File: rtl/light_conflict_monitor.sv
// Safety monitor between the intersection FSM and the lamp drivers.
// Passes light codes through (1-cycle registered), trips a latched fault
// after a conflict persists, flashes red while faulted, and returns to
// pass-through only after operator clear plus an all-red hold.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   enable            monitor enable (NORMAL only)
//   fault_clear       operator clear, level-sampled
//   in_*              nine light codes from the FSM
//   out_*             nine light codes to the lamp drivers
//   fault             high while in FAULT
//   fsm_hold          high in FAULT and ALLRED
//   fault_pair        latched cause (pair 0-13, 15 illegal)
//
// state    | meaning
// NORMAL   | pass-through, persistence filter running
// FAULT    | flashing red, waiting for dwell + clear + clean inputs
// ALLRED   | all outputs red for ALLRED_CYCLES, then NORMAL
module light_conflict_monitor
   import light_pkg::*;
#(
   parameter int PERSIST_CYCLES   = 20,
   parameter int FLASH_HALF       = 5000,
   parameter int MIN_FAULT_CYCLES = 30000,
   parameter int ALLRED_CYCLES    = 20000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       fault_clear,
   input  logic [1:0] in_th,
   input  logic [1:0] in_nn,
   input  logic [1:0] in_ns,
   input  logic [1:0] in_gth,
   input  logic [1:0] in_gnn_l,
   input  logic [1:0] in_gnn_r,
   input  logic [1:0] in_pn,
   input  logic [1:0] in_pth1,
   input  logic [1:0] in_pth2,
   output logic [1:0] out_th,
   output logic [1:0] out_nn,
   output logic [1:0] out_ns,
   output logic [1:0] out_gth,
   output logic [1:0] out_gnn_l,
   output logic [1:0] out_gnn_r,
   output logic [1:0] out_pn,
   output logic [1:0] out_pth1,
   output logic [1:0] out_pth2,
   output logic       fault,
   output logic       fsm_hold,
   output logic [3:0] fault_pair
);

   localparam logic [15:0] PERSIST_C = 16'(PERSIST_CYCLES);
   localparam logic [15:0] FLASH_C   = 16'(FLASH_HALF);
   localparam logic [15:0] MIN_C     = 16'(MIN_FAULT_CYCLES);
   localparam logic [15:0] ALLRED_C  = 16'(ALLRED_CYCLES);

   logic [NUM_HEADS-1:0][1:0] codes_in;
   logic                      any_cause;
   logic [3:0]                cause;

   assign codes_in = {in_pth2, in_pth1, in_pn, in_gnn_r, in_gnn_l,
                      in_gth, in_ns, in_nn, in_th};

   conflict_detect u_detect (
      .codes     (codes_in),
      .any_cause (any_cause),
      .cause     (cause)
   );

   state_e                    state_q, state_d;
   logic [15:0]               persist_q, persist_d;
   logic [15:0]               dwell_q, dwell_d;
   logic [15:0]               flash_q, flash_d;
   logic                      phase_q, phase_d;
   logic [15:0]               allred_q, allred_d;
   logic [NUM_HEADS-1:0][1:0] out_q, out_d;
   logic                      fault_q, fault_d;
   logic                      hold_q, hold_d;
   logic [3:0]                pair_q, pair_d;

   always_comb begin
      state_d   = state_q;
      persist_d = persist_q;
      dwell_d   = dwell_q;
      flash_d   = flash_q;
      phase_d   = phase_q;
      allred_d  = allred_q;
      pair_d    = pair_q;
      out_d     = codes_in;

      case (state_q)
         S_NORMAL: begin
            if (!enable || !any_cause) begin
               persist_d = '0;
            end else if (persist_q >= PERSIST_C - 16'd1) begin
               state_d   = S_FAULT;
               pair_d    = cause;
               persist_d = '0;
               dwell_d   = '0;
               flash_d   = FLASH_C - 16'd1;
               phase_d   = 1'b0;
               out_d     = '0;
            end else if (persist_q != 16'hFFFF) begin
               persist_d = persist_q + 16'd1;
            end
         end

         S_FAULT: begin
            if (dwell_q != MIN_C) dwell_d = dwell_q + 16'd1;
            // Flash half-period timer: reload and toggle on terminal count.
            if (flash_q == 16'd0) begin
               flash_d = FLASH_C - 16'd1;
               phase_d = ~phase_q;
            end else begin
               flash_d = flash_q - 16'd1;
            end
            out_d = '0;
            for (int h = 0; h < NUM_VEHICLE; h++) begin
               out_d[h] = phase_d ? DARK : RED;
            end
            if ((dwell_q == MIN_C) && fault_clear && !any_cause) begin
               state_d  = S_ALLRED;
               allred_d = ALLRED_C - 16'd1;
               out_d    = '0;
            end
         end

         S_ALLRED: begin
            out_d = '0;
            if (allred_q == 16'd0) begin
               state_d   = S_NORMAL;
               pair_d    = 4'd0;
               persist_d = '0;
               out_d     = codes_in;
            end else begin
               allred_d = allred_q - 16'd1;
            end
         end

         default: begin
            state_d = S_NORMAL;
            out_d   = '0;
         end
      endcase

      fault_d = (state_d == S_FAULT);
      hold_d  = (state_d != S_NORMAL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_NORMAL;
         persist_q <= '0;
         dwell_q   <= '0;
         flash_q   <= '0;
         phase_q   <= 1'b0;
         allred_q  <= '0;
         out_q     <= '0;
         fault_q   <= 1'b0;
         hold_q    <= 1'b0;
         pair_q    <= 4'd0;
      end else begin
         state_q   <= state_d;
         persist_q <= persist_d;
         dwell_q   <= dwell_d;
         flash_q   <= flash_d;
         phase_q   <= phase_d;
         allred_q  <= allred_d;
         out_q     <= out_d;
         fault_q   <= fault_d;
         hold_q    <= hold_d;
         pair_q    <= pair_d;
      end
   end

   assign out_th     = out_q[H_TH];
   assign out_nn     = out_q[H_NN];
   assign out_ns     = out_q[H_NS];
   assign out_gth    = out_q[H_GTH];
   assign out_gnn_l  = out_q[H_GNN_L];
   assign out_gnn_r  = out_q[H_GNN_R];
   assign out_pn     = out_q[H_PN];
   assign out_pth1   = out_q[H_PTH1];
   assign out_pth2   = out_q[H_PTH2];
   assign fault      = fault_q;
   assign fsm_hold   = hold_q;
   assign fault_pair = pair_q;

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Scoreboard bench for light_conflict_monitor. Timers are scaled down
// (flash 50, dwell 300, all-red 200) so full fault/clear cycles stay short.
module tb_light_conflict_monitor;

   localparam int PERSIST = 20;
   localparam int HALF    = 50;
   localparam int MINF    = 300;
   localparam int AR      = 200;

   localparam logic [1:0] RD = 2'b00, YE = 2'b01, GR = 2'b10, DK = 2'b11;
   localparam int TH = 0, NN = 1, NS = 2, GTH = 3, GNL = 4, GNR = 5,
                  PN = 6, P1 = 7, P2 = 8;

   logic clk = 1'b0;
   logic reset = 1'b1, enable = 1'b0, fault_clear = 1'b0;
   logic [8:0][1:0] in_v = '0;
   wire  [8:0][1:0] out_v;
   logic fault, fsm_hold;
   logic [3:0] fault_pair;

   typedef struct packed {
      logic [17:0] out;
      logic        flt;
      logic        hold;
      logic [3:0]  pair;
   } exp_t;

   exp_t  sb[$];
   string cur_tag = "reset";
   int    checks = 0;
   int    errors = 0;

   always #50 clk = ~clk;

   light_conflict_monitor #(
      .PERSIST_CYCLES(PERSIST), .FLASH_HALF(HALF),
      .MIN_FAULT_CYCLES(MINF), .ALLRED_CYCLES(AR)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .fault_clear(fault_clear),
      .in_th(in_v[TH]), .in_nn(in_v[NN]), .in_ns(in_v[NS]),
      .in_gth(in_v[GTH]), .in_gnn_l(in_v[GNL]), .in_gnn_r(in_v[GNR]),
      .in_pn(in_v[PN]), .in_pth1(in_v[P1]), .in_pth2(in_v[P2]),
      .out_th(out_v[TH]), .out_nn(out_v[NN]), .out_ns(out_v[NS]),
      .out_gth(out_v[GTH]), .out_gnn_l(out_v[GNL]), .out_gnn_r(out_v[GNR]),
      .out_pn(out_v[PN]), .out_pth1(out_v[P1]), .out_pth2(out_v[P2]),
      .fault(fault), .fsm_hold(fsm_hold), .fault_pair(fault_pair)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of stimulus and queue what the DUT must show after the edge.
   task automatic step(input logic [17:0] v, input logic en, input logic clr,
                       input logic rst, input logic [17:0] eo, input logic ef,
                       input logic eh, input logic [3:0] ep);
      exp_t e;
      @(negedge clk);
      in_v = v; enable = en; fault_clear = clr; reset = rst;
      e.out = eo; e.flt = ef; e.hold = eh; e.pair = ep;
      sb.push_back(e);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({cur_tag, "_out"},   32'(out_v),      32'(e.out));
            chk({cur_tag, "_fault"}, 32'(fault),      32'(e.flt));
            chk({cur_tag, "_hold"},  32'(fsm_hold),   32'(e.hold));
            chk({cur_tag, "_pair"},  32'(fault_pair), 32'(e.pair));
         end
      end
   end

   function automatic logic [17:0] flash(input int k);
      logic [8:0][1:0] r;
      r = '0;
      if (((k / HALF) % 2) == 1) for (int h = 0; h < 6; h++) r[h] = DK;
      return r;
   endfunction

   function automatic logic [17:0] mk(input int a, input logic [1:0] ca,
                                      input int b, input logic [1:0] cb);
      logic [8:0][1:0] r;
      r = '0;
      r[a] = ca;
      r[b] = cb;
      return r;
   endfunction

   // Persist PERSIST-1 cycles of passthrough, then the trip edge.
   task automatic trip(input logic [17:0] v, input logic [3:0] p);
      for (int i = 0; i < PERSIST - 1; i++) step(v, 1, 0, 0, v, 0, 0, 0);
      step(v, 1, 0, 0, flash(0), 1, 1, p);
   endtask

   initial begin
      logic [8:0][1:0] conf, clean, clean2, multi, v;
      logic clr;
      int x;
      conf   = mk(TH, GR, NN, GR);
      clean  = mk(TH, GR, GTH, GR);
      clean2 = mk(NN, GR, NS, YE);
      multi  = mk(TH, GR, NS, GR);
      multi[PN]  = GR;
      multi[GTH] = YE;

      cur_tag = "reset";
      step(conf, 1, 0, 1, '0, 0, 0, 0);
      step(conf, 1, 0, 1, '0, 0, 0, 0);

      cur_tag = "filter";
      for (int i = 0; i < PERSIST - 1; i++) step(conf, 1, 0, 0, conf, 0, 0, 0);
      step(clean, 1, 0, 0, clean, 0, 0, 0);
      for (int i = 0; i < PERSIST - 1; i++) step(conf, 1, 0, 0, conf, 0, 0, 0);
      step(clean, 1, 0, 0, clean, 0, 0, 0);

      cur_tag = "trip_thnn";
      trip(conf, 4'd0);
      cur_tag = "flash";
      for (int k = 1; k <= 2 * HALF + 10; k++) step(clean, 1, 0, 0, flash(k), 1, 1, 0);

      cur_tag = "reset_fault";
      step(conf, 1, 0, 1, '0, 0, 0, 0);
      step(clean, 1, 0, 0, clean, 0, 0, 0);

      cur_tag = "enable_low";
      for (int i = 0; i < 2 * PERSIST; i++) step(conf, 0, 0, 0, conf, 0, 0, 0);
      cur_tag = "enable_trip";
      trip(conf, 4'd0);
      step(conf, 1, 0, 1, '0, 0, 0, 0);

      cur_tag = "illegal";
      v = mk(GTH, YE, TH, RD);
      trip(v, 4'd15);
      for (int k = 1; k <= 3; k++) step(v, 1, 0, 0, flash(k), 1, 1, 15);
      step(clean, 1, 0, 1, '0, 0, 0, 0);

      cur_tag = "priority";
      trip(multi, 4'd1);

      // Clear pulse early is ignored; held clear exits only once dwell is
      // saturated and the inputs are clean (cause present at MINF+1, MINF+2).
      x = MINF + 3;
      for (int k = 1; k <= x + AR + 4; k++) begin
         v   = clean;
         clr = (k == 100) || (k >= MINF - 10);
         if (k < 10 || k == MINF + 1 || k == MINF + 2 || (k >= x + 10 && k < x + 15))
            v = conf;
         if (k >= x + AR) v = clean2;
         if (k < x) begin
            cur_tag = "fault_dwell";
            step(v, 1, clr, 0, flash(k), 1, 1, 1);
         end else if (k < x + AR) begin
            cur_tag = "allred";
            step(v, 1, clr, 0, '0, 0, 1, 1);
         end else begin
            cur_tag = "resume";
            step(v, 1, clr, 0, v, 0, 0, 0);
         end
      end

      @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
